// File: rtl/exe_hazard_controller_pkg.sv
// Shared types and constants for the EXE-stage hazard controller.
// Optional feature macro: FORWARDING_EN (see exe_hazard_controller.sv).
package exe_ctrl_pkg;

    // Memory-wait sequencer states
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Operand source selects driven toward the ALU / Val2 generator
    localparam logic [1:0] SEL_REG = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // Default widths and limits
    localparam int DEF_REG_W    = 4;
    localparam int DEF_CNT_W    = 16;
    localparam int DEF_WAIT_MAX = 16;

    // Wait counter is sized for the largest legal WAIT_MAX (255)
    localparam int WAIT_CNT_W   = 8;

endpackage

// File: rtl/exe_hazard_controller_if.sv
// Bundle of pipeline-side signals seen by the EXE hazard controller.
// The pipeline drives the master side; the controller is the slave.
interface exe_hazard_controller_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);

    logic [REG_W-1:0] id_src1;
    logic [REG_W-1:0] id_src2;
    logic             id_two_src;
    logic [REG_W-1:0] exe_src1;
    logic [REG_W-1:0] exe_src2;
    logic [REG_W-1:0] exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_read_en;
    logic [REG_W-1:0] mem_dest;
    logic             mem_wb_en;
    logic [REG_W-1:0] wb_dest;
    logic             wb_wb_en;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             cnt_clr;

    logic [1:0]       sel_src1;
    logic [1:0]       sel_src2;
    logic             freeze_if;
    logic             freeze_id;
    logic             bubble_id_exe;
    logic             flush_if_id;
    logic             freeze_all;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] wait_cycles;

    modport master (
        output id_src1, id_src2, id_two_src,
        output exe_src1, exe_src2, exe_dest, exe_wb_en, exe_mem_read_en,
        output mem_dest, mem_wb_en, wb_dest, wb_wb_en,
        output br_taken, mem_req, mem_ready, cnt_clr,
        input  sel_src1, sel_src2, freeze_if, freeze_id, bubble_id_exe,
        input  flush_if_id, freeze_all, mem_timeout, stall_cycles, wait_cycles
    );

    modport slave (
        input  id_src1, id_src2, id_two_src,
        input  exe_src1, exe_src2, exe_dest, exe_wb_en, exe_mem_read_en,
        input  mem_dest, mem_wb_en, wb_dest, wb_wb_en,
        input  br_taken, mem_req, mem_ready, cnt_clr,
        output sel_src1, sel_src2, freeze_if, freeze_id, bubble_id_exe,
        output flush_if_id, freeze_all, mem_timeout, stall_cycles, wait_cycles
    );

endinterface

// File: rtl/exe_hazard_controller_forwarding_unit.sv
// Combinational operand-forwarding select generator for the EXE stage.
// With FORWARDING_EN undefined the selects are tied to the register-file
// path; the register file then resolves WB writes in its first half-cycle.
module forwarding_unit
    import exe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] i_exe_src1,
    input  logic [REG_W-1:0] i_exe_src2,
    input  logic [REG_W-1:0] i_mem_dest,
    input  logic             i_mem_wb_en,
    input  logic [REG_W-1:0] i_wb_dest,
    input  logic             i_wb_wb_en,
    output logic [1:0]       o_sel_src1,
    output logic [1:0]       o_sel_src2
);

`ifdef FORWARDING_EN
    // The youngest producer (MEM) wins over the older one (WB)
    function automatic logic [1:0] pick_source(input logic [REG_W-1:0] src,
                                               input logic [REG_W-1:0] mem_dest,
                                               input logic             mem_wb_en,
                                               input logic [REG_W-1:0] wb_dest,
                                               input logic             wb_wb_en);
        logic [1:0] sel;
        sel = SEL_REG;
        if (mem_wb_en && (mem_dest == src)) begin
            sel = SEL_MEM;
        end else if (wb_wb_en && (wb_dest == src)) begin
            sel = SEL_WB;
        end
        return sel;
    endfunction

    // Compare both EXE sources against the in-flight destinations
    always_comb begin
        o_sel_src1 = pick_source(i_exe_src1, i_mem_dest, i_mem_wb_en, i_wb_dest, i_wb_wb_en);
        o_sel_src2 = pick_source(i_exe_src2, i_mem_dest, i_mem_wb_en, i_wb_dest, i_wb_wb_en);
    end
`else
    logic w_unused;

    assign w_unused = ^{i_exe_src1, i_exe_src2, i_mem_dest, i_mem_wb_en, i_wb_dest, i_wb_wb_en};

    // Without forwarding every operand comes straight from the register file
    always_comb begin
        o_sel_src1 = SEL_REG;
        o_sel_src2 = SEL_REG;
    end
`endif

endmodule

// File: rtl/exe_hazard_controller.sv
// EXE-stage pipeline sequencing controller: operand forwarding selects,
// RAW / load-use stalls, branch flush, memory-wait freeze with timeout
// release, and saturating stall / wait statistics.
// Optional feature macro: FORWARDING_EN (forwarding paths and the
// load-use-only hazard rule; otherwise dependents stall until WB).
module exe_hazard_controller
    import exe_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = DEF_WAIT_MAX,
    parameter int REG_W    = DEF_REG_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input logic                   clk,
    input logic                   rst,
    exe_hazard_controller_if.slave bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX   = '1;

    state_t                r_state;
    state_t                w_next_state;
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
    logic [WAIT_CNT_W-1:0] w_wait_cnt_next;
    logic                  r_mem_timeout;
    logic                  w_timeout_set;
    logic                  w_freeze_raw;
    logic                  w_freeze_all;

    logic                  w_match_exe;
    logic                  w_match_mem;
    logic                  w_hz;

    logic                  w_freeze_if;
    logic                  w_freeze_id;
    logic                  w_bubble_id_exe;
    logic                  w_flush_if_id;

    logic [CNT_W-1:0]      r_stall_cnt;
    logic [CNT_W-1:0]      r_wait_stat;

    logic [1:0]            w_sel_src1;
    logic [1:0]            w_sel_src2;

    forwarding_unit #(
        .REG_W (REG_W)
    ) u_forwarding_unit (
        .i_exe_src1  (bus.exe_src1),
        .i_exe_src2  (bus.exe_src2),
        .i_mem_dest  (bus.mem_dest),
        .i_mem_wb_en (bus.mem_wb_en),
        .i_wb_dest   (bus.wb_dest),
        .i_wb_wb_en  (bus.wb_wb_en),
        .o_sel_src1  (w_sel_src1),
        .o_sel_src2  (w_sel_src2)
    );

    // Does the ID instruction read a given destination register?
    assign w_match_exe = (bus.id_src1 == bus.exe_dest) |
                         (bus.id_two_src & (bus.id_src2 == bus.exe_dest));
    assign w_match_mem = (bus.id_src1 == bus.mem_dest) |
                         (bus.id_two_src & (bus.id_src2 == bus.mem_dest));

`ifdef FORWARDING_EN
    logic w_unused;

    // Only a load in EXE cannot be forwarded in time
    assign w_hz     = bus.exe_wb_en & bus.exe_mem_read_en & w_match_exe;
    assign w_unused = w_match_mem;
`else
    logic w_unused;

    // Any producer still in EXE or MEM blocks the dependent instruction
    assign w_hz     = (bus.exe_wb_en & w_match_exe) | (bus.mem_wb_en & w_match_mem);
    assign w_unused = bus.exe_mem_read_en;
`endif

    // Memory-wait sequencer: next state, wait count and freeze request
    always_comb begin
        w_next_state    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_freeze_raw    = 1'b0;
        w_timeout_set   = 1'b0;
        case (r_state)
            RUN: begin
                if (bus.mem_req && !bus.mem_ready) begin
                    w_freeze_raw    = 1'b1;
                    w_next_state    = MEM_WAIT;
                    w_wait_cnt_next = WAIT_CNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    w_next_state    = RUN;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout_set   = 1'b1;
                    w_next_state    = RUN;
                    w_wait_cnt_next = '0;
                end else begin
                    w_freeze_raw    = 1'b1;
                    w_wait_cnt_next = r_wait_cnt + WAIT_CNT_W'(1);
                end
            end
            default: begin
                w_next_state    = RUN;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    // The freeze must release the moment reset is asserted, not at the next edge
    assign w_freeze_all = w_freeze_raw & rst;

    // Sequencer state, wait count and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_cnt_next;
            if (w_timeout_set) begin
                r_mem_timeout <= 1'b1;
            end
        end
    end

    // Pipeline control: freeze beats branch, branch beats hazard
    always_comb begin
        w_freeze_if     = 1'b0;
        w_freeze_id     = 1'b0;
        w_bubble_id_exe = 1'b0;
        w_flush_if_id   = 1'b0;
        if (!w_freeze_all) begin
            if (bus.br_taken) begin
                w_flush_if_id   = 1'b1;
                w_bubble_id_exe = 1'b1;
            end else if (w_hz) begin
                w_freeze_if     = 1'b1;
                w_freeze_id     = 1'b1;
                w_bubble_id_exe = 1'b1;
            end
        end
    end

    // Saturating statistics; a clear request overrides counting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_wait_stat <= '0;
        end else if (bus.cnt_clr) begin
            r_stall_cnt <= '0;
            r_wait_stat <= '0;
        end else begin
            if (w_freeze_id && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_freeze_all && (r_wait_stat != CNT_MAX)) begin
                r_wait_stat <= r_wait_stat + CNT_W'(1);
            end
        end
    end

    assign bus.sel_src1      = w_sel_src1;
    assign bus.sel_src2      = w_sel_src2;
    assign bus.freeze_if     = w_freeze_if;
    assign bus.freeze_id     = w_freeze_id;
    assign bus.bubble_id_exe = w_bubble_id_exe;
    assign bus.flush_if_id   = w_flush_if_id;
    assign bus.freeze_all    = w_freeze_all;
    assign bus.mem_timeout   = r_mem_timeout;
    assign bus.stall_cycles  = r_stall_cnt;
    assign bus.wait_cycles   = r_wait_stat;

endmodule
